// File: rtl/multimode_flip_flop_bank.sv
`default_nettype none
// ============================================================================
//  Module      : multimode_flip_flop_bank
//  Description : WIDTH-bit register bank whose bits behave as SR, JK, D or T
//                flip-flops, selected at run time by a shared mode input.
//                Reports SR-mode S=R=1 conditions through a one-cycle pulse,
//                a sticky flag and a saturating event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multimode_flip_flop_bank #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               SR_POLICY = 0,
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   input  logic             clr_err,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [1:0]       c_MODE_SR = 2'b00;
   localparam logic [1:0]       c_MODE_JK = 2'b01;
   localparam logic [1:0]       c_MODE_D  = 2'b10;
   localparam logic [1:0]       c_MODE_T  = 2'b11;
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [WIDTH-1:0] r_q;
   logic             r_err_pulse;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_count;

   logic [WIDTH-1:0] w_sr_set;
   logic [WIDTH-1:0] w_sr_clr;
   logic [WIDTH-1:0] w_q_next;
   logic             w_illegal;

   // SR-mode set/clear masks; the S=R=1 resolution depends on the policy
   generate
      if (SR_POLICY == 1) begin : g_pol_set_wins
         assign w_sr_set = S;
         assign w_sr_clr = R & ~S;
      end else if (SR_POLICY == 2) begin : g_pol_reset_wins
         assign w_sr_set = S & ~R;
         assign w_sr_clr = R;
      end else begin : g_pol_hold
         assign w_sr_set = S & ~R;
         assign w_sr_clr = R & ~S;
      end
   endgenerate

   // An illegal edge is counted once, however many bits have S=R=1
   assign w_illegal = en && (mode == c_MODE_SR) && (|(S & R));

   // Per-bit next state for the currently sampled mode
   always_comb begin
      w_q_next = r_q;
      case (mode)
         c_MODE_SR: w_q_next = (r_q & ~w_sr_clr) | w_sr_set;
         c_MODE_JK: w_q_next = (S & ~r_q) | (~R & r_q);
         c_MODE_D:  w_q_next = S;
         c_MODE_T:  w_q_next = r_q ^ S;
         default:   w_q_next = r_q;
      endcase
   end

   // State register plus error bookkeeping; an event beats a same-edge clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q          <= RESET_VAL;
         r_err_pulse  <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else begin
         if (en) begin
            r_q <= w_q_next;
         end
         r_err_pulse <= w_illegal;
         if (w_illegal) begin
            r_err_sticky <= 1'b1;
            if (clr_err) begin
               r_err_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_err_count != c_CNT_MAX) begin
               r_err_count <= r_err_count + 1'b1;
            end
         end else if (clr_err) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
         end
      end
   end

   assign Q          = r_q;
   assign Qn         = ~r_q;
   assign err_pulse  = r_err_pulse;
   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_multimode_flip_flop_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multimode_flip_flop_bank
//  Description : Bench for multimode_flip_flop_bank. Three instances with
//                different reset values, SR policies and counter widths share
//                one stimulus stream; a behavioural model predicts each edge
//                and a monitor compares the registered outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multimode_flip_flop_bank;

   typedef struct packed {
      logic [7:0] q;
      logic       pulse;
      logic       sticky;
      logic [7:0] cnt;
   } exp_t;

   typedef struct packed {
      exp_t e2;
      exp_t e1;
      exp_t e0;
   } row_t;

   logic       clk = 1'b0;
   logic       rst, en, clr_err;
   logic [1:0] mode;
   logic [7:0] S, R;

   logic [7:0] q0, qn0, q1, qn1, q2, qn2;
   logic       p0, p1, p2, st0, st1, st2;
   logic [7:0] c0;
   logic [1:0] c1;
   logic [2:0] c2;

   int n_checks = 0;
   int n_fail   = 0;

   row_t sb[$];

   // model state per instance
   logic [7:0] m_q[3];
   logic       m_pulse[3];
   logic       m_sticky[3];
   int         m_cnt[3];

   always #5 clk = ~clk;

   multimode_flip_flop_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R), .clr_err(clr_err),
      .Q(q0), .Qn(qn0), .err_pulse(p0), .err_sticky(st0), .err_count(c0));

   multimode_flip_flop_bank #(.WIDTH(8), .RESET_VAL(8'h00), .SR_POLICY(1), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R), .clr_err(clr_err),
      .Q(q1), .Qn(qn1), .err_pulse(p1), .err_sticky(st1), .err_count(c1));

   multimode_flip_flop_bank #(.WIDTH(8), .RESET_VAL(8'h3C), .SR_POLICY(2), .CNT_W(3)) u2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R), .clr_err(clr_err),
      .Q(q2), .Qn(qn2), .err_pulse(p2), .err_sticky(st2), .err_count(c2));

   function automatic int cnt_max(int k);
      return (k == 0) ? 255 : ((k == 1) ? 3 : 7);
   endfunction

   function automatic logic [7:0] reset_val(int k);
      return (k == 0) ? 8'hA5 : ((k == 1) ? 8'h00 : 8'h3C);
   endfunction

   // Reference model: rules applied bit by bit as a truth table
   task automatic model_edge(int k, bit r_i, bit e_i, logic [1:0] m_i,
                             logic [7:0] s_i, logic [7:0] rr_i, bit c_i);
      logic [7:0] nq;
      bit         illegal;
      illegal = (m_i == 2'd0) && ((s_i & rr_i) != 8'h00);
      for (int i = 0; i < 8; i++) begin
         bit s, r, q, n;
         s = s_i[i]; r = rr_i[i]; q = m_q[k][i];
         case (m_i)
            2'd0: begin
               if (s && !r)       n = 1'b1;
               else if (!s && r)  n = 1'b0;
               else if (!s && !r) n = q;
               else               n = (k == 0) ? q : ((k == 1) ? 1'b1 : 1'b0);
            end
            2'd1: begin
               if (s && !r)       n = 1'b1;
               else if (!s && r)  n = 1'b0;
               else if (!s && !r) n = q;
               else               n = !q;
            end
            2'd2:    n = s;
            default: n = s ? !q : q;
         endcase
         nq[i] = n;
      end
      if (r_i) begin
         m_q[k] = reset_val(k); m_pulse[k] = 1'b0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
      end else begin
         m_pulse[k] = e_i && illegal;
         if (e_i) m_q[k] = nq;
         if (e_i && illegal) begin
            m_sticky[k] = 1'b1;
            if (c_i) m_cnt[k] = 1;
            else if (m_cnt[k] < cnt_max(k)) m_cnt[k] = m_cnt[k] + 1;
         end else if (c_i) begin
            m_sticky[k] = 1'b0;
            m_cnt[k] = 0;
         end
      end
   endtask

   function automatic exp_t snap(int k);
      exp_t e;
      e.q = m_q[k]; e.pulse = m_pulse[k]; e.sticky = m_sticky[k];
      e.cnt = 8'(m_cnt[k]);
      return e;
   endfunction

   // Drive one edge's inputs and queue the predicted post-edge outputs
   task automatic step(bit r_i, bit e_i, logic [1:0] m_i,
                       logic [7:0] s_i, logic [7:0] rr_i, bit c_i);
      row_t row;
      rst = r_i; en = e_i; mode = m_i; S = s_i; R = rr_i; clr_err = c_i;
      for (int k = 0; k < 3; k++) model_edge(k, r_i, e_i, m_i, s_i, rr_i, c_i);
      row.e0 = snap(0); row.e1 = snap(1); row.e2 = snap(2);
      sb.push_back(row);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, int k, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   task automatic cmp_dut(int k, logic [7:0] q, logic [7:0] qn, logic p,
                          logic st, logic [7:0] c, exp_t e);
      chk("Q", k, q, e.q);
      chk("Qn", k, qn, ~e.q);
      chk("err_pulse", k, {7'd0, p}, {7'd0, e.pulse});
      chk("err_sticky", k, {7'd0, st}, {7'd0, e.sticky});
      chk("err_count", k, c, e.cnt);
   endtask

   // Monitor: one prediction is consumed after every driven edge
   always @(negedge clk) begin : mon
      row_t r;
      if (sb.size() != 0) begin
         r = sb.pop_front();
         cmp_dut(0, q0, qn0, p0, st0, c0, r.e0);
         cmp_dut(1, q1, qn1, p1, st1, {6'd0, c1}, r.e1);
         cmp_dut(2, q2, qn2, p2, st2, {5'd0, c2}, r.e2);
      end
   end

   initial begin : stim
      rst = 1'b1; en = 1'b0; mode = 2'd0; S = 8'h00; R = 8'h00; clr_err = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_q[k] = 8'h00; m_pulse[k] = 1'b0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
      end
      // reset, then reset overriding an enabled D load
      step(1, 0, 2'd0, 8'h00, 8'h00, 0);
      step(1, 1, 2'd2, 8'hFF, 8'h00, 1);
      // SR basics from Q=00
      step(0, 1, 2'd2, 8'h00, 8'h00, 0);
      step(0, 1, 2'd0, 8'h0F, 8'h00, 0);
      step(0, 1, 2'd0, 8'h00, 8'h03, 0);
      step(0, 1, 2'd0, 8'h00, 8'h00, 0);
      step(0, 0, 2'd0, 8'hFF, 8'h00, 0);
      // three illegal edges, then a clear with no event
      for (int i = 0; i < 3; i++) step(0, 1, 2'd0, 8'h01, 8'h01, 0);
      step(0, 1, 2'd0, 8'h00, 8'h00, 1);
      // JK toggle-all and T mode from Q=F0
      step(0, 1, 2'd2, 8'hF0, 8'h00, 0);
      step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
      step(0, 1, 2'd3, 8'h81, 8'h00, 0);
      step(0, 1, 2'd3, 8'h00, 8'h00, 0);
      // counter saturation, then clear colliding with an event
      for (int i = 0; i < 5; i++) step(0, 1, 2'd0, 8'h10, 8'h10, 0);
      step(0, 1, 2'd0, 8'h10, 8'h10, 1);
      // disabled illegal pattern records nothing but clear still acts
      step(0, 0, 2'd0, 8'hFF, 8'hFF, 0);
      step(0, 0, 2'd0, 8'hFF, 8'hFF, 1);
      // mode switching every cycle
      step(0, 1, 2'd2, 8'h3C, 8'h00, 0);
      step(0, 1, 2'd3, 8'hFF, 8'h00, 0);
      step(0, 1, 2'd0, 8'h01, 8'h00, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [7:0] s_r, r_r;
         s_r = 8'($urandom);
         r_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & ~s_r);
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
              2'($urandom_range(0, 3)), s_r, r_r, ($urandom_range(0, 9) == 0));
      end
      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d predictions left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
